mp3_spi_sched: RTL and testbench



---
 rtl/mp3_pkg.sv | 44 ++++
 rtl/sck_tick_gen.sv | 35 +++
 rtl/mp3_spi_sched.sv | 201 ++++++++++++++++++++
 tb/tb_mp3_spi_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// Shared definitions for the VS10xx serial-bus scheduler.
//   - FSM state encoding
//   - SCI/SDI word widths
//   - SCI opcodes and register addresses, plus a helper that packs an SCI word
package mp3_pkg;

  localparam int unsigned CMD_BITS  = 32;
  localparam int unsigned DATA_BITS = 16;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CMD_SHIFT  = 2'd1,
    ST_DATA_SHIFT = 2'd2,
    ST_GAP        = 2'd3
  } state_t;

  // SCI opcodes
  localparam logic [7:0] SCI_WRITE = 8'h02;
  localparam logic [7:0] SCI_READ  = 8'h03;

  // SCI register addresses
  localparam logic [7:0] SCI_MODE = 8'h00;
  localparam logic [7:0] SCI_VOL  = 8'h0B;

  // SCI control word layout, sent MSB first
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  addr;
    logic [15:0] data;
  } sci_word_t;

  // Build a 32-bit SCI word from its fields
  function automatic logic [CMD_BITS-1:0] sci_pack(input logic [7:0]  opcode,
                                                   input logic [7:0]  addr,
                                                   input logic [15:0] data);
    sci_word_t w;
    w.opcode = opcode;
    w.addr   = addr;
    w.data   = data;
    return CMD_BITS'(w);
  endfunction

endpackage

// File: rtl/sck_tick_gen.sv
// SCK half-period tick generator.
//   CLK    : system clock
//   rst    : synchronous active-high reset
//   en     : count enable; counter is held at 0 while low
//   clr    : synchronous clear of the counter
//   tick_c : combinational pulse on the last count of each DIV-cycle period
module sck_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  // Free-running 0..DIV-1 counter while enabled
  always_ff @(posedge CLK) begin
    if (rst || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mp3_spi_sched.sv
// Scheduler sharing one VS10xx serial bus between the SCI command port
// (32-bit words, XCS) and the SDI data port (16-bit words, XDCS).
//   CLK, rst            : clock, synchronous active-high reset
//   i_DREQ              : chip ready; gates new grants only
//   cmd_valid/cmd_word  : SCI request;  cmd_ready pulses on accept
//   cmd_done            : pulse as XCS returns high after an SCI word
//   data_valid/data_word: SDI request;  data_ready pulses on accept
//   o_XCS, o_XDCS       : active-low chip selects
//   o_SCK, o_SI         : serial clock and MSB-first data
//   busy                : high from grant until the scheduler is idle again
module mp3_spi_sched
  import mp3_pkg::*;
#(
  parameter int unsigned SCK_DIV       = 10,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned MAX_CMD_BURST = 4
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 i_DREQ,
  input  logic                 cmd_valid,
  input  logic [CMD_BITS-1:0]  cmd_word,
  output logic                 cmd_ready,
  output logic                 cmd_done,
  input  logic                 data_valid,
  input  logic [DATA_BITS-1:0] data_word,
  output logic                 data_ready,
  output logic                 o_XCS,
  output logic                 o_XDCS,
  output logic                 o_SCK,
  output logic                 o_SI,
  output logic                 busy
);

  localparam int unsigned SHIFT_W = $clog2(2 * CMD_BITS + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_TICKS + 1);
  localparam int unsigned TCW     = (GAP_W > SHIFT_W) ? GAP_W : SHIFT_W;
  localparam int unsigned BW      = (MAX_CMD_BURST > 1) ? $clog2(MAX_CMD_BURST + 1) : 1;
  localparam int unsigned PAD_W   = CMD_BITS - DATA_BITS;

  localparam logic [TCW-1:0] CMD_LAST  = TCW'(2 * CMD_BITS - 1);
  localparam logic [TCW-1:0] DATA_LAST = TCW'(2 * DATA_BITS - 1);
  localparam logic [TCW-1:0] GAP_LAST  = TCW'(GAP_TICKS - 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_CMD_BURST);

  state_t              state, state_d;
  logic [CMD_BITS-1:0] sr, sr_d;
  logic [TCW-1:0]      tcnt, tcnt_d;
  logic [BW-1:0]       burst, burst_d;
  logic                xcs_d, xdcs_d, sck_d, si_d;
  logic                cmd_ready_d, data_ready_d, cmd_done_d, busy_d;
  logic                grant_cmd_c, grant_data_c;
  logic                tick_c;
  logic                burst_sat_c;
  logic [TCW-1:0]      shift_last_c;

  // SCK half-period timebase, running only while a word or gap is in progress
  sck_tick_gen #(
    .DIV (SCK_DIV)
  ) u_tick (
    .CLK    (CLK),
    .rst    (rst),
    .en     (state != ST_IDLE),
    .clr    (grant_cmd_c || grant_data_c),
    .tick_c (tick_c)
  );

  assign burst_sat_c  = (burst == BURST_MAX);
  assign shift_last_c = (state == ST_CMD_SHIFT) ? CMD_LAST : DATA_LAST;

  // Arbitration: commands first, but yield to pending data after a full burst
  always_comb begin
    grant_cmd_c  = 1'b0;
    grant_data_c = 1'b0;
    if (state == ST_IDLE && i_DREQ) begin
      if (cmd_valid && !(data_valid && burst_sat_c)) begin
        grant_cmd_c = 1'b1;
      end else if (data_valid) begin
        grant_data_c = 1'b1;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    sr_d         = sr;
    tcnt_d       = tcnt;
    burst_d      = burst;
    xcs_d        = o_XCS;
    xdcs_d       = o_XDCS;
    sck_d        = o_SCK;
    si_d         = o_SI;
    cmd_ready_d  = 1'b0;
    data_ready_d = 1'b0;
    cmd_done_d   = 1'b0;
    // busy stays up through the first IDLE cycle after a word
    busy_d       = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (grant_cmd_c) begin
          state_d     = ST_CMD_SHIFT;
          sr_d        = cmd_word;
          si_d        = cmd_word[CMD_BITS-1];
          xcs_d       = 1'b0;
          sck_d       = 1'b0;
          tcnt_d      = '0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b1;
          if (data_valid) begin
            burst_d = burst_sat_c ? burst : burst + BW'(1);
          end else begin
            burst_d = '0;
          end
        end else if (grant_data_c) begin
          state_d      = ST_DATA_SHIFT;
          sr_d         = {data_word, {PAD_W{1'b0}}};
          si_d         = data_word[DATA_BITS-1];
          xdcs_d       = 1'b0;
          sck_d        = 1'b0;
          tcnt_d       = '0;
          data_ready_d = 1'b1;
          busy_d       = 1'b1;
          burst_d      = '0;
        end
      end

      ST_CMD_SHIFT, ST_DATA_SHIFT: begin
        if (tick_c) begin
          if (!o_SCK) begin
            // odd tick: rising edge, chip samples o_SI
            sck_d  = 1'b1;
            tcnt_d = tcnt + TCW'(1);
          end else if (tcnt == shift_last_c) begin
            // final tick: close the word
            sck_d      = 1'b0;
            xcs_d      = 1'b1;
            xdcs_d     = 1'b1;
            cmd_done_d = (state == ST_CMD_SHIFT);
            tcnt_d     = '0;
            state_d    = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
          end else begin
            // even tick: falling edge, present the next bit
            sck_d  = 1'b0;
            sr_d   = sr << 1;
            si_d   = sr[CMD_BITS-2];
            tcnt_d = tcnt + TCW'(1);
          end
        end
      end

      ST_GAP: begin
        if (tick_c) begin
          if (tcnt == GAP_LAST) begin
            tcnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            tcnt_d = tcnt + TCW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= ST_IDLE;
      sr         <= '0;
      tcnt       <= '0;
      burst      <= '0;
      o_XCS      <= 1'b1;
      o_XDCS     <= 1'b1;
      o_SCK      <= 1'b0;
      o_SI       <= 1'b0;
      cmd_ready  <= 1'b0;
      data_ready <= 1'b0;
      cmd_done   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      sr         <= sr_d;
      tcnt       <= tcnt_d;
      burst      <= burst_d;
      o_XCS      <= xcs_d;
      o_XDCS     <= xdcs_d;
      o_SCK      <= sck_d;
      o_SI       <= si_d;
      cmd_ready  <= cmd_ready_d;
      data_ready <= data_ready_d;
      cmd_done   <= cmd_done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_mp3_spi_sched.sv
// Self-checking bench for mp3_spi_sched (SCK_DIV=2, GAP_TICKS=2, MAX_CMD_BURST=4).
// The reference model tracks each transfer by its grant cycle and derives every
// output from elapsed time, word length and the arbitration rules.
module tb_mp3_spi_sched;
  import mp3_pkg::*;

  localparam int DIV  = 2;
  localparam int GAP  = 2;
  localparam int MAXB = 4;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        dreq = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_word = '0;
  logic        data_valid = 1'b0;
  logic [15:0] data_word = '0;
  logic        cmd_ready, cmd_done, data_ready;
  logic        o_XCS, o_XDCS, o_SCK, o_SI, busy;

  mp3_spi_sched #(
    .SCK_DIV       (DIV),
    .GAP_TICKS     (GAP),
    .MAX_CMD_BURST (MAXB)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .i_DREQ     (dreq),
    .cmd_valid  (cmd_valid),
    .cmd_word   (cmd_word),
    .cmd_ready  (cmd_ready),
    .cmd_done   (cmd_done),
    .data_valid (data_valid),
    .data_word  (data_word),
    .data_ready (data_ready),
    .o_XCS      (o_XCS),
    .o_XDCS     (o_XDCS),
    .o_SCK      (o_SCK),
    .o_SI       (o_SI),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int          t = 0;
  int          g = 0;
  int          n = 0;
  int          next_ok = 0;
  int          burst_m = 0;
  bit          act = 1'b0;
  bit          cmd_m = 1'b0;
  logic [31:0] word_m = '0;

  // bus monitor state
  logic        prev_sck = 1'b0;
  logic        prev_xcs = 1'b1;
  logic        prev_xdcs = 1'b1;
  logic [31:0] mon_bits = '0;
  int          mon_cnt = 0;

  int cnt_dr = 0;
  int cnt_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // Advance one clock edge, update the model with the inputs present at it, check outputs.
  task automatic cycle();
    logic        a_rst, a_dreq, a_cv, a_dv;
    logic [31:0] a_cw;
    logic [15:0] a_dw;
    logic [6:0]  exp_o, got_o;
    logic        e_xcs, e_xdcs, e_sck, e_cr, e_dr, e_done, e_busy;
    int          d;
    a_rst = rst; a_dreq = dreq; a_cv = cmd_valid; a_dv = data_valid;
    a_cw = cmd_word; a_dw = data_word;
    @(posedge CLK);
    #1;
    t++;
    if (a_rst) begin
      act = 1'b0;
      burst_m = 0;
      next_ok = t + 1;
    end else if (t >= next_ok && a_dreq && (a_cv || a_dv)) begin
      act = 1'b1;
      g = t;
      cmd_m = a_cv && !(a_dv && burst_m == MAXB);
      if (cmd_m) begin
        n = 32;
        word_m = a_cw;
        burst_m = a_dv ? ((burst_m < MAXB) ? burst_m + 1 : MAXB) : 0;
      end else begin
        n = 16;
        word_m = {16'h0000, a_dw};
        burst_m = 0;
      end
      next_ok = t + (2 * n + GAP) * DIV + 1;
    end

    e_xcs = 1'b1; e_xdcs = 1'b1; e_sck = 1'b0; e_cr = 1'b0; e_dr = 1'b0;
    e_done = 1'b0; e_busy = 1'b0;
    d = t - g;
    if (act) begin
      if (d < 2 * n * DIV) begin
        if (cmd_m) e_xcs = 1'b0;
        else e_xdcs = 1'b0;
        e_sck = ((d / DIV) % 2) == 1;
      end
      if (d == 0) begin
        e_cr = cmd_m;
        e_dr = !cmd_m;
      end
      e_done = cmd_m && (d == 2 * n * DIV);
      e_busy = (d <= (2 * n + GAP) * DIV);
    end
    exp_o = {e_xcs, e_xdcs, e_sck, e_cr, e_dr, e_done, e_busy};
    got_o = {o_XCS, o_XDCS, o_SCK, cmd_ready, data_ready, cmd_done, busy};
    check("outs{xcs,xdcs,sck,crdy,drdy,done,busy}", 32'(got_o), 32'(exp_o));
    if (a_rst) check("si_reset", 32'(o_SI), 32'd0);
    else if (act && d < 2 * n * DIV) check("si_bit", 32'(o_SI), 32'(word_m[n - 1 - (d / DIV) / 2]));

    // bus-level view: bits sampled on SCK rising edges, checked when CS closes
    if (a_rst) begin
      mon_bits = '0;
      mon_cnt = 0;
    end else begin
      if (!prev_sck && o_SCK && !(o_XCS && o_XDCS)) begin
        mon_bits = {mon_bits[30:0], o_SI};
        mon_cnt++;
      end
      if ((!prev_xcs && o_XCS) || (!prev_xdcs && o_XDCS)) begin
        check("bus_word", mon_bits, word_m);
        check("bus_edges", 32'(mon_cnt), 32'(n));
        mon_bits = '0;
        mon_cnt = 0;
      end
    end
    prev_sck = o_SCK; prev_xcs = o_XCS; prev_xdcs = o_XDCS;
    if (data_ready === 1'b1) cnt_dr++;
    if (cmd_done === 1'b1) cnt_done++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    run(cycles);
    rst = 1'b0;
  endtask

  initial begin
    int dr0, done0, grants, tries;
    logic [1:0] exp_g;

    // reset state
    do_reset(3);

    // single SCI volume write
    dreq = 1'b1;
    cmd_word = sci_pack(SCI_WRITE, SCI_VOL, 16'h0000);
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (cmd_ready === 1'b1) break;
    end
    cmd_valid = 1'b0;
    cmd_word = 32'hFFFF_FFFF;
    run(140);

    // single SDI word
    data_word = 16'hA5C3;
    data_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (data_ready === 1'b1) break;
    end
    data_valid = 1'b0;
    data_word = 16'h0000;
    run(80);

    // DREQ low blocks both requesters; command wins once DREQ rises
    dreq = 1'b0;
    cmd_valid = 1'b1; cmd_word = 32'h0200_0804;
    data_valid = 1'b1; data_word = 16'h1234;
    run(20);
    dreq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (cmd_ready === 1'b1 || data_ready === 1'b1) break;
    end
    check("first_grant_is_cmd", 32'({cmd_ready, data_ready}), 32'b10);
    cmd_valid = 1'b0; data_valid = 1'b0;
    run(140);

    // DREQ drops at bit 5 of a data word: word completes, no regrant until DREQ returns
    data_word = 16'h5A3C;
    data_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (data_ready === 1'b1) break;
    end
    data_word = 16'hC001;
    run(20);
    dreq = 1'b0;
    dr0 = cnt_dr;
    run(100);
    check("no_grant_while_dreq_low", 32'(cnt_dr - dr0), 32'd0);
    dreq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (data_ready === 1'b1) break;
    end
    data_valid = 1'b0;
    run(80);

    // both requesters saturated: C,C,C,C,D repeating
    do_reset(2);
    cmd_valid = 1'b1; data_valid = 1'b1;
    grants = 0;
    tries = 0;
    while (grants < 10 && tries < 1500) begin
      cmd_word = $urandom;
      data_word = 16'($urandom);
      cycle();
      tries++;
      if (cmd_ready === 1'b1 || data_ready === 1'b1) begin
        exp_g = (grants % 5 == 4) ? 2'b01 : 2'b10;
        check("grant_order", 32'({cmd_ready, data_ready}), 32'(exp_g));
        grants++;
      end
    end
    check("grant_order_count", 32'(grants), 32'd10);
    cmd_valid = 1'b0; data_valid = 1'b0;
    run(140);

    // reset mid DATA_SHIFT aborts the word silently
    data_word = 16'hBEEF;
    data_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (data_ready === 1'b1) break;
    end
    data_valid = 1'b0;
    run(20);
    do_reset(3);
    dr0 = cnt_dr;
    done0 = cnt_done;
    run(150);
    check("abort_no_data_ready", 32'(cnt_dr - dr0), 32'd0);
    check("abort_no_cmd_done", 32'(cnt_done - done0), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (cmd_ready === 1'b1 || !cmd_valid) cmd_valid = ($urandom_range(0, 5) == 0);
      if (data_ready === 1'b1 || !data_valid) data_valid = ($urandom_range(0, 2) == 0);
      dreq = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 1999) == 0);
      cmd_word = $urandom;
      data_word = 16'($urandom);
      cycle();
    end
    rst = 1'b0;
    cmd_valid = 1'b0; data_valid = 1'b0;
    run(150);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
